// File: rtl/integrator_vth_v3.sv
`default_nettype none
// ============================================================================
// Module   : integrator_vth_v3
// Purpose  : Shift-scaled loop integrator with saturation, threshold cut and
//            bumpless gain change. Define INTEG_VTH_EVT_CNT_EN to enable the
//            signed threshold-event counter on o_evt_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module integrator_vth_v3 #(
    parameter int DATA_W    = 32,
    parameter int EXT_W     = 16,
    parameter int MAX_SHIFT = 15,
    parameter int RST_SHIFT = 5,
    parameter int INT_LIMIT = 2_000_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_err,
    input  logic                     i_zero,
    input  logic        [4:0]        i_gain_sel,
    input  logic                     i_gain_mode,
    input  logic        [DATA_W-1:0] i_sat,
    input  logic        [DATA_W-1:0] i_vth,
    input  logic                     i_vth_cut_mode,
    input  logic                     i_add_sig_en,
    input  logic signed [EXT_W-1:0]  i_ext_sig,
    output logic signed [DATA_W-1:0] o_int,
    output logic                     o_valid,
    output logic        [2:0]        o_state,
    output logic                     o_vth_evt_p,
    output logic                     o_vth_evt_n,
    output logic                     o_lim,
    output logic signed [15:0]       o_evt_cnt
);

    localparam int c_AW = DATA_W + 2;
    // Working width leaves headroom for a full 31-bit shift of any operand.
    localparam int c_WW = DATA_W + 40;

    localparam logic [2:0] c_ST_NORMAL   = 3'd0;
    localparam logic [2:0] c_ST_CAL_DIFF = 3'd1;
    localparam logic [2:0] c_ST_SAT_P    = 3'd2;
    localparam logic [2:0] c_ST_SAT_N    = 3'd3;
    localparam logic [2:0] c_ST_VTH_P    = 3'd4;
    localparam logic [2:0] c_ST_VTH_N    = 3'd5;

    localparam logic signed [c_WW-1:0] c_LIM  = c_WW'(INT_LIMIT);
    localparam logic signed [c_WW-1:0] c_OMAX = {{(c_WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_WW-1:0] c_OMIN = ~c_OMAX;
    localparam logic        [4:0]      c_MAX_SH = 5'(MAX_SHIFT);
    localparam logic        [4:0]      c_RST_SH = 5'(RST_SHIFT);

    logic signed [c_AW-1:0]   r_acc;
    logic signed [DATA_W-1:0] r_dv;
    logic        [4:0]        r_sh;
    logic        [4:0]        r_gcopy;
    logic        [2:0]        r_state;
    logic signed [DATA_W-1:0] r_int;
    logic                     r_valid;
    logic                     r_evt_p;
    logic                     r_evt_n;

    logic signed [c_WW-1:0]   w_acc_x, w_dv_x, w_err_x, w_sat_x, w_vth_x, w_cut_x, w_ext_x;
    logic signed [c_WW-1:0]   w_integ, w_sat_acc, w_acc_nx, w_integ_nx, w_sum_ext;
    logic signed [DATA_W-1:0] w_dv_nx, w_int_nx;
    logic        [4:0]        w_gsel_eff, w_sh_nx, w_gcopy_nx;
    logic        [2:0]        w_state_nx;
    logic                     w_take, w_evt_p, w_evt_n;

    function automatic logic signed [c_WW-1:0] f_clamp(input logic signed [c_WW-1:0] v);
        if (v > c_LIM)       return c_LIM;
        else if (v < -c_LIM) return -c_LIM;
        else                 return v;
    endfunction

    always_comb begin
        w_acc_x    = c_WW'(r_acc);
        w_dv_x     = c_WW'(r_dv);
        w_err_x    = c_WW'(i_err);
        w_sat_x    = c_WW'(i_sat);
        w_vth_x    = c_WW'(i_vth);
        w_cut_x    = i_vth_cut_mode ? (w_vth_x <<< 1) : w_vth_x;
        w_ext_x    = c_WW'(i_ext_sig);
        w_integ    = (w_acc_x >>> r_sh) + w_dv_x;
        w_gsel_eff = (i_gain_sel > c_MAX_SH) ? c_MAX_SH : i_gain_sel;
        w_sat_acc  = (r_state == c_ST_SAT_P) ? f_clamp((w_sat_x - w_dv_x) <<< r_sh)
                                             : f_clamp((-w_sat_x - w_dv_x) <<< r_sh);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_dv    <= '0;
            r_sh    <= c_RST_SH;
            r_gcopy <= i_gain_sel;
            r_state <= c_ST_NORMAL;
            r_int   <= '0;
            r_valid <= 1'b0;
            r_evt_p <= 1'b0;
            r_evt_n <= 1'b0;
        end else begin
            r_acc   <= c_AW'(w_acc_nx);
            r_dv    <= w_dv_nx;
            r_sh    <= w_sh_nx;
            r_gcopy <= w_gcopy_nx;
            r_state <= w_state_nx;
            r_int   <= w_int_nx;
            r_valid <= w_take;
            r_evt_p <= w_evt_p;
            r_evt_n <= w_evt_n;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = w_acc_x;
        w_dv_nx    = r_dv;
        w_sh_nx    = r_sh;
        w_gcopy_nx = r_gcopy;
        w_take     = 1'b0;
        w_evt_p    = 1'b0;
        w_evt_n    = 1'b0;
        case (r_state)
            c_ST_NORMAL: begin
                // A sample is only absorbed on cycles where no event is pending.
                if (i_gain_sel != r_gcopy)                                w_state_nx = c_ST_CAL_DIFF;
                else if (w_integ >= w_sat_x && !i_err[DATA_W-1])          w_state_nx = c_ST_SAT_P;
                else if (w_integ <= -w_sat_x && i_err[DATA_W-1])          w_state_nx = c_ST_SAT_N;
                else if (w_integ > w_vth_x)                               w_state_nx = c_ST_VTH_P;
                else if (w_integ < -w_vth_x)                              w_state_nx = c_ST_VTH_N;
                else if (i_en) begin
                    w_acc_nx = f_clamp(w_acc_x + w_err_x);
                    w_take   = 1'b1;
                end
            end
            c_ST_CAL_DIFF: begin
                w_sh_nx    = w_gsel_eff;
                w_gcopy_nx = i_gain_sel;
                if (i_gain_mode)
                    w_dv_nx = DATA_W'(w_integ - (w_acc_x >>> w_gsel_eff));
                w_state_nx = c_ST_NORMAL;
            end
            c_ST_SAT_P, c_ST_SAT_N: begin
                w_acc_nx = w_sat_acc;
                if (i_en && (i_err[DATA_W-1] == (r_state == c_ST_SAT_P))) begin
                    w_acc_nx   = f_clamp(w_sat_acc + w_err_x);
                    w_take     = 1'b1;
                    w_state_nx = c_ST_NORMAL;
                end
            end
            c_ST_VTH_P: begin
                w_acc_nx   = f_clamp(w_acc_x - (w_cut_x <<< r_sh));
                w_evt_p    = 1'b1;
                w_state_nx = c_ST_NORMAL;
            end
            c_ST_VTH_N: begin
                w_acc_nx   = f_clamp(w_acc_x + (w_cut_x <<< r_sh));
                w_evt_n    = 1'b1;
                w_state_nx = c_ST_NORMAL;
            end
            default: w_state_nx = c_ST_NORMAL;
        endcase
        if (i_zero) begin
            w_state_nx = c_ST_NORMAL;
            w_acc_nx   = '0;
            w_dv_nx    = '0;
            w_sh_nx    = r_sh;
            w_gcopy_nx = r_gcopy;
            w_take     = 1'b0;
            w_evt_p    = 1'b0;
            w_evt_n    = 1'b0;
        end
        // o_int tracks the integrator value that will be held after this edge.
        w_integ_nx = (w_acc_nx >>> w_sh_nx) + c_WW'(w_dv_nx);
        w_sum_ext  = w_integ_nx + w_ext_x;
        if (!i_add_sig_en)          w_int_nx = DATA_W'(w_integ_nx);
        else if (w_sum_ext > c_OMAX) w_int_nx = DATA_W'(c_OMAX);
        else if (w_sum_ext < c_OMIN) w_int_nx = DATA_W'(c_OMIN);
        else                         w_int_nx = DATA_W'(w_sum_ext);
    end

`ifdef INTEG_VTH_EVT_CNT_EN
    logic signed [15:0] r_evt_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_evt_cnt <= '0;
        else if (i_zero)  r_evt_cnt <= '0;
        else if (w_evt_p) r_evt_cnt <= r_evt_cnt + 16'sd1;
        else if (w_evt_n) r_evt_cnt <= r_evt_cnt - 16'sd1;
    end
    assign o_evt_cnt = r_evt_cnt;
`else
    assign o_evt_cnt = '0;
`endif

    assign o_int       = r_int;
    assign o_valid     = r_valid;
    assign o_state     = r_state;
    assign o_vth_evt_p = r_evt_p;
    assign o_vth_evt_n = r_evt_n;
    assign o_lim       = (w_acc_x == c_LIM) || (w_acc_x == -c_LIM);

endmodule
`default_nettype wire

// File: tb/tb_integrator_vth_v3.sv
`default_nettype none
// ============================================================================
// Module   : tb_integrator_vth_v3
// Purpose  : Directed scoreboard bench for integrator_vth_v3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_integrator_vth_v3;

`ifdef INTEG_VTH_EVT_CNT_EN
    localparam int c_CNT_ON = 1;
`else
    localparam int c_CNT_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, en, zero, gain_mode, cut_mode, add_sig_en;
    logic signed [31:0] err;
    logic        [4:0]  gain_sel;
    logic        [31:0] sat, vth;
    logic signed [15:0] ext_sig;
    logic signed [31:0] o_int;
    logic               o_valid, o_evt_p, o_evt_n, o_lim;
    logic        [2:0]  o_state;
    logic signed [15:0] o_evt_cnt;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_q[$];

    integrator_vth_v3 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_err(err), .i_zero(zero),
        .i_gain_sel(gain_sel), .i_gain_mode(gain_mode), .i_sat(sat), .i_vth(vth),
        .i_vth_cut_mode(cut_mode), .i_add_sig_en(add_sig_en), .i_ext_sig(ext_sig),
        .o_int(o_int), .o_valid(o_valid), .o_state(o_state),
        .o_vth_evt_p(o_evt_p), .o_vth_evt_n(o_evt_n), .o_lim(o_lim),
        .o_evt_cnt(o_evt_cnt)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic do_zero();
        zero = 1'b1;
        tick();
        zero = 1'b0;
        chk("zero_o_int", longint'(o_int), 0);
        chk("zero_evt_cnt", longint'(o_evt_cnt), 0);
    endtask

    task automatic set_gain(input logic [4:0] g, input logic mode);
        gain_sel  = g;
        gain_mode = mode;
        tick();
        chk("gain_cal_state", longint'(o_state), 1);
        tick();
        chk("gain_norm_state", longint'(o_state), 0);
    endtask

    // Scoreboard monitor: every o_valid consumes one expected o_int.
    initial begin : mon
        longint e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: o_valid with o_int=%0d, required no output", o_int);
                end else begin
                    e = exp_q.pop_front();
                    if (longint'(o_int) != e) begin
                        n_fail++;
                        $display("FAIL sb_o_int: got %0d, required %0d", o_int, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; zero = 1'b0; gain_mode = 1'b0; cut_mode = 1'b0;
        add_sig_en = 1'b0; err = '0; gain_sel = 5'd1; sat = 32'd10000; vth = 32'd1000;
        ext_sig = '0;
        tick(2);
        chk("rst_o_int", longint'(o_int), 0);
        chk("rst_o_valid", longint'(o_valid), 0);
        chk("rst_o_state", longint'(o_state), 0);
        chk("rst_evt_p", longint'(o_evt_p), 0);
        chk("rst_evt_n", longint'(o_evt_n), 0);
        chk("rst_evt_cnt", longint'(o_evt_cnt), 0);
        rst_n = 1'b1;
        set_gain(5'd0, 1'b0);

        // Threshold cut by vth
        err = 300; en = 1'b1;
        exp_q.push_back(300); exp_q.push_back(600); exp_q.push_back(900); exp_q.push_back(1200);
        tick(4);
        tick();
        chk("vth1_state", longint'(o_state), 4);
        tick();
        chk("vth1_state_back", longint'(o_state), 0);
        chk("vth1_evt_p", longint'(o_evt_p), 1);
        chk("vth1_o_int", longint'(o_int), 200);
        chk("vth1_evt_cnt", longint'(o_evt_cnt), c_CNT_ON);
        en = 1'b0;
        tick();
        chk("vth1_evt_p_end", longint'(o_evt_p), 0);
        do_zero();

        // Threshold cut by 2*vth
        cut_mode = 1'b1; en = 1'b1;
        exp_q.push_back(300); exp_q.push_back(600); exp_q.push_back(900); exp_q.push_back(1200);
        tick(5);
        tick();
        chk("vth2_o_int", longint'(o_int), -800);
        chk("vth2_evt_p", longint'(o_evt_p), 1);
        en = 1'b0; cut_mode = 1'b0;
        do_zero();

        // Positive saturation and release with opposite-sign error
        sat = 32'd500; vth = 32'h7FFF_FFFF; err = 200; en = 1'b1;
        exp_q.push_back(200); exp_q.push_back(400); exp_q.push_back(600);
        tick(3);
        tick();
        chk("satp_state", longint'(o_state), 2);
        tick();
        chk("satp_hold_state", longint'(o_state), 2);
        chk("satp_o_int", longint'(o_int), 500);
        err = -100;
        exp_q.push_back(400);
        tick();
        chk("satp_exit_state", longint'(o_state), 0);
        en = 1'b0;
        do_zero();

        // Bumpless gain change 0 -> 2
        sat = 32'd10000; err = 1024; en = 1'b1;
        exp_q.push_back(1024);
        tick();
        en = 1'b0;
        gain_sel = 5'd2; gain_mode = 1'b1;
        tick();
        chk("bump_cal_state", longint'(o_state), 1);
        chk("bump_o_int_a", longint'(o_int), 1024);
        tick();
        chk("bump_o_int_b", longint'(o_int), 1024);
        err = 4; en = 1'b1;
        exp_q.push_back(1025);
        tick();
        en = 1'b0;
        do_zero();

        // Build integ = 0x7FFFFFF0 via the offset, then saturate the output sum
        sat = 32'hFFFF_FFFF; vth = 32'hFFFF_FFFF;
        set_gain(5'd15, 1'b0);
        err = -2_000_000_000; en = 1'b1;
        exp_q.push_back(-61036);
        tick();
        en = 1'b0;
        chk("lim_at_clamp", longint'(o_lim), 1);
        set_gain(5'd0, 1'b1);
        chk("bump2_o_int", longint'(o_int), -61036);
        err = 2_000_000_000; en = 1'b1;
        exp_q.push_back(1999938964);
        tick();
        chk("lim_released", longint'(o_lim), 0);
        err = 147544668;
        exp_q.push_back(longint'(32'h7FFF_FFF0));
        tick();
        en = 1'b0;
        add_sig_en = 1'b1; ext_sig = 16'sh0100;
        tick();
        chk("ext_sat_pos", longint'(o_int), longint'(32'h7FFF_FFFF));
        ext_sig = -16'sd256;
        tick();
        chk("ext_add_neg", longint'(o_int), longint'(32'h7FFF_FEF0));
        add_sig_en = 1'b0; ext_sig = '0;
        do_zero();

        // Reset asserted during SAT_N
        sat = 32'd500; err = -300; en = 1'b1;
        exp_q.push_back(-300); exp_q.push_back(-600);
        tick(2);
        tick();
        chk("satn_state", longint'(o_state), 3);
        #2;
        rst_n = 1'b0; gain_sel = 5'd1; en = 1'b0;
        #1;
        chk("mrst_o_int", longint'(o_int), 0);
        chk("mrst_o_state", longint'(o_state), 0);
        chk("mrst_o_valid", longint'(o_valid), 0);
        tick(2);
        chk("mrst_evt_cnt", longint'(o_evt_cnt), 0);
        rst_n = 1'b1;
        sat = 32'd10000; vth = 32'hFFFF_FFFF; err = 320; en = 1'b1;
        exp_q.push_back(10);
        tick();
        en = 1'b0;
        chk("mrst_state_after", longint'(o_state), 0);
        chk("mrst_evt_p", longint'(o_evt_p), 0);
        do_zero();

        // Negative threshold cut
        set_gain(5'd0, 1'b0);
        vth = 32'd1000; err = -600; en = 1'b1;
        exp_q.push_back(-600); exp_q.push_back(-1200);
        tick(2);
        en = 1'b0;
        tick();
        chk("vthn_state", longint'(o_state), 5);
        tick();
        chk("vthn_evt_n", longint'(o_evt_n), 1);
        chk("vthn_o_int", longint'(o_int), -200);
        chk("vthn_evt_cnt", longint'(o_evt_cnt), -c_CNT_ON);
        tick();
        chk("vthn_evt_n_end", longint'(o_evt_n), 0);

        tick(2);
        chk("sb_drain", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
